dut_cmd_engine: RTL and testbench

DUT_CMD_ENGINE -- requirements
Module: dut_cmd_engine

---
 rtl/dut_cmd_engine.sv | 204 ++++++++++++++++++++
 tb/tb_dut_cmd_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_cmd_engine.sv
// UART command engine driving a scan-based DUT: shift in/out/exchange, set PIs, read POs, execute, free-run.
// Optional acknowledge bytes ('k' on completion, '?' on unknown) enabled by defining CMD_ENGINE_ACK_EN.
module dut_cmd_engine #(
    parameter int NPIS    = 14,
    parameter int NPOS    = 11,
    parameter int NCHAINS = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_ready,
    output logic [NPIS-1:0]    dut_pis,
    input  logic [NPOS-1:0]    dut_pos,
    output logic               dut_clk,
    output logic               scan_en,
    output logic               test_mode,
    output logic [NCHAINS-1:0] scan_in,
    input  logic [NCHAINS-1:0] scan_out,
    output logic               busy
);
    localparam logic [7:0] C_R = 8'h72, C_S = 8'h73, C_G = 8'h67, C_X = 8'h78;
    localparam logic [7:0] C_I = 8'h69, C_O = 8'h6F, C_E = 8'h65, C_F = 8'h66;
    localparam logic [7:0] C_P = 8'h70, C_0 = 8'h30, C_1 = 8'h31;
    localparam logic [7:0] C_K = 8'h6B, C_Q = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE, S_ARG_HI, S_ARG_LO, S_SH_WAIT, S_SH_DRV, S_IN_WAIT, S_OUT_LD,
        S_TX_REQ, S_TX_LO, S_TX_HI, S_CYC_HI, S_CYC_LO, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [7:0]          r_cmd, r_txb;
    logic [CNT_W-1:0]    r_cnt, r_idx, w_n;
    logic [NPOS-1:0]     r_snap;
    logic [NPIS-1:0]     r_pis;
    logic [NCHAINS-1:0]  r_sin;
    logic                r_ack, r_stop;
    logic                w_last, w_func, w_pstop;

    // r_cnt holds the high byte after ARG_HI; the truncation drops it for 8-bit counts
    assign w_n     = CNT_W'({r_cnt, rx_data});
    assign w_last  = (r_cnt == CNT_W'(1));
    assign w_pstop = rx_valid && (rx_data == C_P);
    assign w_func  = ((r_state == S_CYC_HI) || (r_state == S_CYC_LO)) &&
                     ((r_cmd == C_E) || (r_cmd == C_F));

    assign busy      = (r_state != S_IDLE);
    assign scan_en   = !w_func;
    assign test_mode = !w_func;
    assign tx_data   = r_txb;
    assign dut_pis   = r_pis;
    assign scan_in   = r_sin;

`ifdef CMD_ENGINE_ACK_EN
    logic w_known;
    assign w_known = rx_data inside {C_R, C_S, C_G, C_X, C_I, C_O, C_E, C_F};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        tx_start = 1'b0;
        dut_clk  = 1'b0;
        case (r_state)
            S_IDLE: if (rx_valid) begin
                case (rx_data)
                    C_S, C_G, C_X, C_I, C_E: w_next = (CNT_W > 8) ? S_ARG_HI : S_ARG_LO;
                    C_O:     w_next = S_OUT_LD;
                    C_F:     w_next = S_CYC_HI;
                    C_R:     w_next = S_IDLE;
                    default: begin
`ifdef CMD_ENGINE_ACK_EN
                        w_next = S_TX_REQ;
`else
                        w_next = S_IDLE;
`endif
                    end
                endcase
            end
            S_ARG_HI:  if (rx_valid) w_next = S_ARG_LO;
            S_ARG_LO: if (rx_valid) begin
                if (w_n == '0) w_next = S_DONE;
                else begin
                    case (r_cmd)
                        C_S, C_X: w_next = S_SH_WAIT;
                        C_G:      w_next = S_SH_DRV;
                        C_I:      w_next = S_IN_WAIT;
                        default:  w_next = S_CYC_HI;
                    endcase
                end
            end
            S_SH_WAIT: if (rx_valid) w_next = S_SH_DRV;
            S_SH_DRV:  w_next = (r_cmd == C_S) ? S_CYC_HI : S_TX_REQ;
            S_IN_WAIT: if (rx_valid) w_next = w_last ? S_DONE : S_IN_WAIT;
            S_OUT_LD:  w_next = S_TX_REQ;
            S_TX_REQ: begin
                tx_start = tx_ready;
                if (tx_ready) w_next = S_TX_LO;
            end
            S_TX_LO:   if (!tx_ready) w_next = S_TX_HI;
            S_TX_HI: if (tx_ready) begin
                if (r_ack)              w_next = S_IDLE;
                else if (r_cmd == C_O)  w_next = (r_idx == CNT_W'(NPOS - 1)) ? S_DONE : S_OUT_LD;
                else                    w_next = S_CYC_HI;
            end
            S_CYC_HI: begin
                dut_clk = 1'b1;
                w_next  = S_CYC_LO;
            end
            S_CYC_LO: begin
                if (r_cmd == C_F)  w_next = (r_stop || w_pstop) ? S_DONE : S_CYC_HI;
                else if (w_last)   w_next = S_DONE;
                else begin
                    case (r_cmd)
                        C_E:     w_next = S_CYC_HI;
                        C_G:     w_next = S_SH_DRV;
                        default: w_next = S_SH_WAIT;
                    endcase
                end
            end
            S_DONE: begin
`ifdef CMD_ENGINE_ACK_EN
                w_next = S_TX_REQ;
`else
                w_next = S_IDLE;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmd  <= '0;
            r_txb  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_snap <= '0;
            r_pis  <= '0;
            r_sin  <= '0;
            r_ack  <= 1'b0;
            r_stop <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (rx_valid) begin
                    r_cmd  <= rx_data;
                    r_cnt  <= '0;
                    r_idx  <= '0;
                    r_stop <= 1'b0;
                    r_ack  <= 1'b0;
                    if (rx_data == C_R) begin
                        r_pis <= '0;
                        r_sin <= '0;
                        r_txb <= '0;
                    end
                    if (rx_data == C_O) r_snap <= dut_pos;
`ifdef CMD_ENGINE_ACK_EN
                    if (!w_known) begin
                        r_txb <= C_Q;
                        r_ack <= 1'b1;
                    end
`endif
                end
                S_ARG_HI:  if (rx_valid) r_cnt <= CNT_W'(rx_data);
                S_ARG_LO:  if (rx_valid) r_cnt <= w_n;
                S_SH_WAIT: if (rx_valid) r_sin <= rx_data[NCHAINS-1:0];
                S_SH_DRV:  if (r_cmd != C_S) r_txb <= 8'(scan_out);
                S_IN_WAIT: if (rx_valid) begin
                    // bytes beyond NPIS match no index and are consumed silently
                    for (int j = 0; j < NPIS; j++) begin
                        if (r_idx == CNT_W'(j)) begin
                            if (rx_data == C_0)      r_pis[j] <= 1'b0;
                            else if (rx_data == C_1) r_pis[j] <= 1'b1;
                        end
                    end
                    r_idx <= r_idx + 1'b1;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_OUT_LD: begin
                    r_txb  <= r_snap[0] ? C_1 : C_0;
                    r_snap <= r_snap >> 1;
                end
                S_TX_HI:  if (tx_ready && !r_ack && (r_cmd == C_O)) r_idx <= r_idx + 1'b1;
                S_CYC_HI: if (w_pstop) r_stop <= 1'b1;
                S_CYC_LO: if (r_cmd != C_F) r_cnt <= r_cnt - 1'b1;
                S_DONE: begin
`ifdef CMD_ENGINE_ACK_EN
                    r_txb <= C_K;
                    r_ack <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dut_cmd_engine.sv
// Randomized bench for dut_cmd_engine with a command-level reference model, UART responder and DUT-cycle monitor.
module tb_dut_cmd_engine;
    localparam int NPIS = 14, NPOS = 11, NCHAINS = 2, CNT_W = 16;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [7:0]         rx_data = '0;
    logic               rx_valid = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_ready = 1'b1;
    logic [NPIS-1:0]    dut_pis;
    logic [NPOS-1:0]    dut_pos = '0;
    logic               dut_clk, scan_en, test_mode, busy;
    logic [NCHAINS-1:0] scan_in, scan_out;

    dut_cmd_engine #(.NPIS(NPIS), .NPOS(NPOS), .NCHAINS(NCHAINS), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
        .dut_pis(dut_pis), .dut_pos(dut_pos), .dut_clk(dut_clk),
        .scan_en(scan_en), .test_mode(test_mode), .scan_in(scan_in),
        .scan_out(scan_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int pulse_cnt = 0, bad_hi = 0, bad_start = 0, tx_dly = 0, p0 = 0;
    logic prev_dclk = 1'b0;
    logic [NCHAINS-1:0] so_pat [256];
    logic [7:0]         tx_q[$], exp_q[$];
    logic [NCHAINS-1:0] sin_q[$], exp_sin[$];
    logic [1:0]         mode_q[$];
    logic [NPIS-1:0]    m_pis = '0;

    // scan_out advances to the next pattern entry after each DUT clock rise
    assign scan_out = so_pat[pulse_cnt[7:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        prev_dclk <= dut_clk;
        if (dut_clk && !prev_dclk) begin
            pulse_cnt <= pulse_cnt + 1;
            sin_q.push_back(scan_in);
            mode_q.push_back({scan_en, test_mode});
        end
        if (dut_clk && prev_dclk) bad_hi <= bad_hi + 1;
    end

    // UART transmitter: goes busy for a few clocks after each accepted byte
    always @(posedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (!tx_ready) bad_start <= bad_start + 1;
            tx_ready <= 1'b0;
            tx_dly   <= $urandom_range(4, 1);
        end else if (!tx_ready) begin
            if (tx_dly == 0) tx_ready <= 1'b1;
            else             tx_dly   <= tx_dly - 1;
        end
    end

    task automatic rx(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] c, input int n);
        rx(c);
        rx(8'(n >> 8));
        rx(8'(n));
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        @(negedge clk);
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_pulse(input int target);
        int t = 0;
        while (pulse_cnt < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("pulse timeout", 64'(pulse_cnt), 64'(target));
        @(negedge clk);
    endtask

    task automatic ack_exp();
`ifdef CMD_ENGINE_ACK_EN
        exp_q.push_back(8'h6B);
`endif
    endtask

    task automatic begin_cmd();
        tx_q.delete(); exp_q.delete(); sin_q.delete(); exp_sin.delete(); mode_q.delete();
        p0 = pulse_cnt;
    endtask

    task automatic cmp_tx(input string tag);
        chk({tag, " txlen"}, 64'(tx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++)
            chk({tag, " txbyte"}, 64'(tx_q[i]), 64'(exp_q[i]));
    endtask

    task automatic count_modes(input string tag, input logic [1:0] want);
        int bad = 0;
        foreach (mode_q[i]) if (mode_q[i] !== want) bad++;
        chk({tag, " mode"}, 64'(bad), 64'd0);
    endtask

    task automatic cmd_e(input int n);
        begin_cmd();
        send_n(8'h65, n);
        wait_idle("e");
        ack_exp();
        chk("e pulses", 64'(pulse_cnt - p0), 64'(n));
        count_modes("e", 2'b00);
        cmp_tx("e");
    endtask

    task automatic cmd_shift(input logic [7:0] c, input int n, input bit directed);
        logic [7:0] b;
        int bad = 0;
        begin_cmd();
        send_n(c, n);
        for (int k = 0; k < n; k++) begin
            b = directed ? 8'(k + 1) : 8'($urandom);
            if (c != 8'h67) begin
                exp_sin.push_back(b[NCHAINS-1:0]);
                rx(b);
            end
            if (c != 8'h73) exp_q.push_back(8'(so_pat[(p0 + k) % 256]));
            wait_pulse(p0 + k + 1);
        end
        wait_idle("shift");
        ack_exp();
        chk("shift pulses", 64'(pulse_cnt - p0), 64'(n));
        count_modes("shift", 2'b11);
        if (c != 8'h67) begin
            for (int i = 0; i < sin_q.size() && i < exp_sin.size(); i++)
                if (sin_q[i] !== exp_sin[i]) bad++;
            chk("shift scan_in", 64'(bad), 64'd0);
        end
        cmp_tx("shift");
    endtask

    task automatic cmd_i(input logic [7:0] bs[$]);
        begin_cmd();
        send_n(8'h69, bs.size());
        foreach (bs[k]) begin
            if (k < NPIS) begin
                if (bs[k] == 8'h30)      m_pis[k] = 1'b0;
                else if (bs[k] == 8'h31) m_pis[k] = 1'b1;
            end
            rx(bs[k]);
        end
        wait_idle("i");
        ack_exp();
        chk("i pis", 64'(dut_pis), 64'(m_pis));
        chk("i pulses", 64'(pulse_cnt - p0), 64'd0);
        cmp_tx("i");
    endtask

    task automatic cmd_o(input logic [NPOS-1:0] pos);
        begin_cmd();
        dut_pos = pos;
        rx(8'h6F);
        dut_pos = ~pos;
        for (int k = 0; k < NPOS; k++) exp_q.push_back(pos[k] ? 8'h31 : 8'h30);
        wait_idle("o");
        ack_exp();
        cmp_tx("o");
    endtask

    task automatic cmd_f(input int w);
        begin_cmd();
        rx(8'h66);
        repeat (w / 2) @(negedge clk);
        rx(8'h61);
        repeat (w - w / 2) @(negedge clk);
        rx(8'h70);
        wait_idle("f");
        ack_exp();
        chk("f dut_clk low", 64'(dut_clk), 64'd0);
        chk("f pulses", 64'((pulse_cnt - p0) >= (w / 2 - 2)), 64'd1);
        chk("f scan_en idle", 64'({scan_en, test_mode}), 64'd3);
        count_modes("f", 2'b00);
        cmp_tx("f");
    endtask

    task automatic cmd_r();
        begin_cmd();
        rx(8'h72);
        @(negedge clk);
        m_pis = '0;
        chk("r pis", 64'(dut_pis), 64'(m_pis));
        chk("r scan_in", 64'(scan_in), 64'd0);
        chk("r busy", 64'(busy), 64'd0);
        cmp_tx("r");
    endtask

    task automatic cmd_unk();
        begin_cmd();
        rx(8'h7A);
        wait_idle("unk");
`ifdef CMD_ENGINE_ACK_EN
        exp_q.push_back(8'h3F);
`endif
        chk("unk pulses", 64'(pulse_cnt - p0), 64'd0);
        cmp_tx("unk");
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " tx_start"}, 64'(tx_start), 64'd0);
        chk({tag, " tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, " dut_pis"}, 64'(dut_pis), 64'd0);
        chk({tag, " dut_clk"}, 64'(dut_clk), 64'd0);
        chk({tag, " scan_in"}, 64'(scan_in), 64'd0);
        chk({tag, " scan_en/test_mode"}, 64'({scan_en, test_mode}), 64'd3);
        chk({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] bs[$];
        string lit;
        int ntx, npc;
        for (int i = 0; i < 256; i++) so_pat[i] = NCHAINS'($urandom);
        #1 chk_reset("por");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        cmd_e(5);
        cmd_e(0);
        cmd_shift(8'h73, 3, 1'b1);
        cmd_shift(8'h67, 4, 1'b0);
        cmd_shift(8'h78, 4, 1'b0);
        lit = "1010101010101011";
        bs.delete();
        for (int k = 0; k < lit.len(); k++) bs.push_back(lit[k]);
        cmd_i(bs);
        chk("i directed", 64'(dut_pis), 64'(14'b01010101010101));
        cmd_o(11'h401);
        cmd_f(37);
        cmd_unk();

        // reset in the middle of a shift-out must stop all activity
        begin_cmd();
        send_n(8'h67, 40);
        wait_pulse(p0 + 3);
        #2 rstn = 1'b0;
        #1 chk_reset("midreset");
        m_pis = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ntx = tx_q.size();
        npc = pulse_cnt;
        repeat (60) @(negedge clk);
        chk("midreset no tx", 64'(tx_q.size()), 64'(ntx));
        chk("midreset no pulses", 64'(pulse_cnt), 64'(npc));

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(8, 0))
                0: cmd_e($urandom_range(12, 0));
                1: cmd_shift(8'h73, $urandom_range(6, 0), 1'b0);
                2: cmd_shift(8'h67, $urandom_range(6, 0), 1'b0);
                3: cmd_shift(8'h78, $urandom_range(6, 0), 1'b0);
                4: begin
                    bs.delete();
                    repeat ($urandom_range(20, 0)) begin
                        case ($urandom_range(2, 0))
                            0:       bs.push_back(8'h30);
                            1:       bs.push_back(8'h31);
                            default: bs.push_back(8'h61);
                        endcase
                    end
                    cmd_i(bs);
                end
                5: cmd_o(NPOS'($urandom));
                6: cmd_f($urandom_range(40, 10));
                7: cmd_r();
                default: cmd_unk();
            endcase
        end

        chk("dut_clk high width", 64'(bad_hi), 64'd0);
        chk("tx_start gated by tx_ready", 64'(bad_start), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
